ps2_host_ctrl: RTL and testbench

- Host-side PS/2 line controller for the keyboard port, clocked by pclk.
- Owns the shared keyboard clock/data lines and arbitrates them between keyboard-to-host receive and host-to-keyboard command transmit (reset 0xFF, LED 0xED, etc.).
- Applies flow-control inhibit when the downstream scan-code path is not ready.
- Replaces raw keyboard-clock-domain capture: all lines are synchronized into pclk, and parity and framing are checked.

---
 rtl/ps2_host_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_ps2_host_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_ctrl.sv
// rtl/ps2_host_ctrl.sv - host-side PS/2 keyboard line controller with rx/tx arbitration
// Open-drain clock/data owner: receives scan codes, sends commands, inhibits on back-pressure.
module ps2_host_ctrl #(
    parameter int INHIBIT_CYCLES = 500,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic       kbd_clk_in,
    input  logic       kbd_data_in,
    output logic       kbd_clk_oe,
    output logic       kbd_data_oe,
    input  logic       tx_req,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       rx_hold,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err
);
    localparam int TMAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {IDLE, RX, HOLD, INHIBIT, RTS, TX, ACK} state_t;
    state_t state_q, state_d;

    logic          clk_s1_q, clk_s2_q, clk_prev_q, data_s1_q, data_s2_q;
    logic          fall;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [3:0]    bit_q, bit_d;
    logic [9:0]    shift_q, shift_d;
    logic          pend_q, pend_d;
    logic [7:0]    tx_byte_q, tx_byte_d;
    logic          tx_out_q, tx_out_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_err_q, tx_done_q, tx_err_q;
    logic          rx_ok, rx_bad, tx_ok, tx_bad;
    logic          tmr_expired, inhibit_done, accept;
    logic [9:0]    tx_frame;

    // Synchronizers idle high so reset never fabricates a falling edge on an idle line.
    always_ff @(posedge pclk) begin
        if (reset) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            data_s1_q  <= 1'b1;
            data_s2_q  <= 1'b1;
        end else begin
            clk_s1_q   <= kbd_clk_in;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            data_s1_q  <= kbd_data_in;
            data_s2_q  <= data_s1_q;
        end
    end

    assign fall         = clk_prev_q & ~clk_s2_q;
    assign tmr_expired  = (tmr_q == TW'(TIMEOUT_CYCLES - 1));
    assign inhibit_done = (tmr_q == TW'(INHIBIT_CYCLES - 1));
    assign tx_frame     = {1'b1, ~^tx_byte_q, tx_byte_q};
    assign accept       = tx_req & ~tx_busy;

    always_ff @(posedge pclk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        rx_ok   = 1'b0;
        rx_bad  = 1'b0;
        tx_ok   = 1'b0;
        tx_bad  = 1'b0;
        case (state_q)
            IDLE: begin
                if (fall && !data_s2_q) state_d = RX;
                else if (pend_q)        state_d = INHIBIT;
                else if (rx_hold)       state_d = HOLD;
            end
            RX: begin
                if (bit_q == 4'd10) begin
                    state_d = IDLE;
                    if (shift_q[9] && ^shift_q[8:0]) rx_ok  = 1'b1;
                    else                             rx_bad = 1'b1;
                end else if (!fall && tmr_expired) begin
                    state_d = IDLE;
                    rx_bad  = 1'b1;
                end
            end
            HOLD: begin
                if (pend_q)        state_d = INHIBIT;
                else if (!rx_hold) state_d = IDLE;
            end
            INHIBIT: if (inhibit_done) state_d = RTS;
            RTS:     state_d = TX;
            TX: begin
                if (fall) begin
                    if (bit_q == 4'd9) state_d = ACK;
                end else if (tmr_expired) begin
                    state_d = IDLE;
                    tx_bad  = 1'b1;
                end
            end
            ACK: begin
                if (fall) begin
                    state_d = IDLE;
                    if (data_s2_q) tx_bad = 1'b1;
                    else           tx_ok  = 1'b1;
                end else if (tmr_expired) begin
                    state_d = IDLE;
                    tx_bad  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        kbd_clk_oe  = 1'b0;
        kbd_data_oe = 1'b0;
        case (state_q)
            HOLD, INHIBIT: kbd_clk_oe  = 1'b1;
            RTS:           kbd_data_oe = 1'b1;
            TX:            kbd_data_oe = ~tx_out_q;
            default:       ;
        endcase
        tx_busy = pend_q | (state_q inside {INHIBIT, RTS, TX, ACK});
    end

    // The inhibit count ignores falls: our own clock pull-down shows up as one.
    always_comb begin
        if (state_d != state_q || state_q == IDLE || state_q == HOLD) tmr_d = '0;
        else if (fall && state_q != INHIBIT)                          tmr_d = '0;
        else                                                          tmr_d = tmr_q + 1'b1;

        if (state_d != state_q)                   bit_d = 4'd0;
        else if (fall && (state_q == RX || state_q == TX)) bit_d = bit_q + 4'd1;
        else                                      bit_d = bit_q;

        shift_d   = (state_q == RX && fall) ? {data_s2_q, shift_q[9:1]} : shift_q;
        tx_out_d  = (state_q != TX) ? 1'b0 : (fall ? tx_frame[bit_q] : tx_out_q);
        pend_d    = (state_q == RTS) ? 1'b0 : (accept ? 1'b1 : pend_q);
        tx_byte_d = accept ? tx_data : tx_byte_q;
        rx_data_d = rx_ok ? shift_q[7:0] : rx_data_q;
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            tmr_q      <= '0;
            bit_q      <= 4'd0;
            shift_q    <= 10'd0;
            tx_out_q   <= 1'b0;
            pend_q     <= 1'b0;
            tx_byte_q  <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
            tx_done_q  <= 1'b0;
            tx_err_q   <= 1'b0;
        end else begin
            tmr_q      <= tmr_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_out_q   <= tx_out_d;
            pend_q     <= pend_d;
            tx_byte_q  <= tx_byte_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_ok;
            rx_err_q   <= rx_bad;
            tx_done_q  <= tx_ok;
            tx_err_q   <= tx_bad;
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_err   = rx_err_q;
    assign tx_done  = tx_done_q;
    assign tx_err   = tx_err_q;
endmodule

// File: tb/tb_ps2_host_ctrl.sv
// tb/tb_ps2_host_ctrl.sv - self-checking bench for ps2_host_ctrl
// Bench keyboard drives open-drain lines; an event scoreboard and line rules are checked every cycle.
module tb_ps2_host_ctrl;
    localparam int HALF = 20;
    localparam int INH  = 500;
    localparam int TMO  = 20000;
    localparam int EV_RXOK = 0, EV_RXERR = 1, EV_TXDONE = 2, EV_TXERR = 3;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } ev_t;

    logic       pclk = 1'b0;
    logic       reset = 1'b1;
    logic       kb_clk_drv = 1'b1;
    logic       kb_data_drv = 1'b1;
    logic       kbd_clk_in, kbd_data_in, kbd_clk_oe, kbd_data_oe;
    logic       tx_req = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_busy, tx_done, tx_err;
    logic       rx_hold = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, rx_err;

    int         checks = 0;
    int         errors = 0;
    ev_t        exp_q[$];
    logic [7:0] m_rx = 8'h00;
    int         run_len = 0, last_run = 0;
    int         oe_cnt = 0, busy_low_cnt = 0;
    int         busy_snap0 = 0, busy_snap1 = 0;
    logic [3:0] prev_pulse = 4'd0;

    always #5 pclk = ~pclk;
    assign kbd_clk_in  = kb_clk_drv & ~kbd_clk_oe;
    assign kbd_data_in = kb_data_drv & ~kbd_data_oe;

    ps2_host_ctrl #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .pclk(pclk), .reset(reset),
        .kbd_clk_in(kbd_clk_in), .kbd_data_in(kbd_data_in),
        .kbd_clk_oe(kbd_clk_oe), .kbd_data_oe(kbd_data_oe),
        .tx_req(tx_req), .tx_data(tx_data), .tx_busy(tx_busy),
        .tx_done(tx_done), .tx_err(tx_err), .rx_hold(rx_hold),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int kind_of(input logic [3:0] p);
        if (p[3]) return EV_RXOK;
        if (p[2]) return EV_RXERR;
        if (p[1]) return EV_TXDONE;
        return EV_TXERR;
    endfunction

    always @(negedge pclk) begin : mon
        logic [3:0] p;
        ev_t        e;
        if (reset) begin
            m_rx       = 8'h00;
            run_len    = 0;
            prev_pulse = 4'd0;
        end else begin
            p = {rx_valid, rx_err, tx_done, tx_err};
            chk("pulse_exclusive", 32'($onehot0(p)), 1);
            chk("pulse_width", 32'(p & prev_pulse), 0);
            chk("oe_exclusive", 32'(kbd_clk_oe & kbd_data_oe), 0);
            chk("data_drive_only_tx", 32'(kbd_data_oe & ~tx_busy), 0);
            if (p != 4'd0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", 32'(p), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_kind", 32'(kind_of(p)), 32'(e.kind));
                    if (e.kind == EV_RXOK) begin
                        chk("rx_byte", 32'(rx_data), 32'(e.data));
                        m_rx = e.data;
                    end
                end
            end
            chk("rx_data_held", 32'(rx_data), 32'(m_rx));
            if (kbd_clk_oe) run_len++;
            else if (run_len != 0) begin
                last_run = run_len;
                run_len  = 0;
            end
            if (kbd_clk_oe || kbd_data_oe) oe_cnt++;
            if (!tx_busy) busy_low_cnt++;
            prev_pulse = p;
        end
    end

    task automatic hold(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic kb_send(input logic [7:0] b, input bit bad_par, input bit with_tx,
                           input logic [7:0] txb, input int nbits);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        if (nbits == 11) begin
            if (bad_par) exp_q.push_back('{EV_RXERR, 8'h00});
            else         exp_q.push_back('{EV_RXOK, b});
        end
        for (int i = 0; i < nbits; i++) begin
            @(negedge pclk);
            kb_data_drv = fr[i];
            hold(HALF);
            kb_clk_drv = 1'b0;
            if (with_tx && i == 0) begin
                // two synchronizer stages later the DUT sees the fall; tx_req lands in that cycle
                @(posedge pclk);
                @(posedge pclk);
                @(negedge pclk);
                tx_req  = 1'b1;
                tx_data = txb;
                @(negedge pclk);
                tx_req     = 1'b0;
                busy_snap0 = busy_low_cnt;
                hold(HALF - 2);
            end else begin
                hold(HALF);
            end
            kb_clk_drv = 1'b1;
        end
        hold(HALF);
    endtask

    task automatic kb_pulse(output logic s);
        @(negedge pclk);
        kb_clk_drv = 1'b0;
        hold(HALF);
        kb_clk_drv = 1'b1;
        hold(2);
        s = kbd_data_in;
        hold(HALF - 2);
    endtask

    task automatic wait_rts(output bit seen);
        int n;
        n = 0;
        while (!kbd_data_oe && n < 2000) begin
            @(negedge pclk);
            n++;
        end
        seen = kbd_data_oe;
        chk("tx_rts_seen", 32'(kbd_data_oe), 1);
    endtask

    task automatic kb_recv(input logic [7:0] b, input bit ack);
        logic [9:0] fr;
        logic       s;
        bit         seen;
        fr = {1'b1, ~^b, b};
        wait_rts(seen);
        if (!seen) return;
        chk("tx_rts_clk_released", 32'(kbd_clk_oe), 0);
        @(negedge pclk);
        chk("tx_inhibit_len", 32'(last_run), INH);
        hold(10);
        for (int k = 0; k < 10; k++) begin
            kb_pulse(s);
            chk($sformatf("tx_bit%0d", k), 32'(s), 32'(fr[k]));
        end
        kb_data_drv = ack;
        exp_q.push_back('{ack ? EV_TXERR : EV_TXDONE, 8'h00});
        busy_snap1 = busy_low_cnt;
        kb_pulse(s);
        kb_data_drv = 1'b1;
        hold(4);
    endtask

    task automatic send_cmd(input logic [7:0] b);
        @(negedge pclk);
        tx_req  = 1'b1;
        tx_data = b;
        @(negedge pclk);
        tx_req = 1'b0;
        chk("cmd_busy", 32'(tx_busy), 1);
    endtask

    initial begin : stim
        int   n;
        bit   seen;
        logic s;
        repeat (3) @(posedge pclk);
        #1 reset = 1'b0;
        @(negedge pclk);
        chk("rst_clk_oe", 32'(kbd_clk_oe), 0);
        chk("rst_data_oe", 32'(kbd_data_oe), 0);
        chk("rst_busy", 32'(tx_busy), 0);
        chk("rst_pulses", 32'({rx_valid, rx_err, tx_done, tx_err}), 0);
        chk("rst_rx_data", 32'(rx_data), 0);

        n = oe_cnt;
        kb_send(8'h1C, 1'b0, 1'b0, 8'h00, 11);
        chk("rx1_lines_quiet", 32'(oe_cnt - n), 0);
        chk("rx1_data", 32'(rx_data), 32'h1C);
        kb_send(8'h1C, 1'b1, 1'b0, 8'h00, 11);
        chk("rx2_data_kept", 32'(rx_data), 32'h1C);

        @(negedge pclk);
        rx_hold = 1'b1;
        hold(10);
        chk("hold_clk_oe", 32'(kbd_clk_oe), 1);
        rx_hold = 1'b0;
        hold(3);
        chk("hold_released", 32'(kbd_clk_oe), 0);

        send_cmd(8'hFF);
        kb_recv(8'hFF, 1'b0);
        chk("tx1_busy_clear", 32'(tx_busy), 0);

        send_cmd(8'hFF);
        kb_recv(8'hFF, 1'b1);
        chk("tx2_busy_clear", 32'(tx_busy), 0);
        chk("tx2_lines_free", 32'({kbd_clk_oe, kbd_data_oe}), 0);

        kb_send(8'hAA, 1'b0, 1'b1, 8'hED, 11);
        chk("conc_rx_data", 32'(rx_data), 32'hAA);
        kb_recv(8'hED, 1'b0);
        chk("conc_busy_held", 32'(busy_snap1 - busy_snap0), 0);

        exp_q.push_back('{EV_RXERR, 8'h00});
        kb_send(8'h00, 1'b0, 1'b0, 8'h00, 5);
        n = 0;
        while (!rx_err && n < 25000) begin
            @(negedge pclk);
            n++;
        end
        chk("tmo_fired", 32'(rx_err), 1);
        chk("tmo_window", 32'(n >= 19900 && n <= 20050), 1);
        kb_data_drv = 1'b1;
        hold(10);

        send_cmd(8'h55);
        wait_rts(seen);
        hold(10);
        repeat (3) kb_pulse(s);
        @(posedge pclk);
        #1 reset = 1'b1;
        @(posedge pclk);
        #1 reset = 1'b0;
        @(negedge pclk);
        chk("midtx_rst_clk_oe", 32'(kbd_clk_oe), 0);
        chk("midtx_rst_data_oe", 32'(kbd_data_oe), 0);
        chk("midtx_rst_busy", 32'(tx_busy), 0);
        chk("midtx_rst_pulses", 32'({rx_valid, rx_err, tx_done, tx_err}), 0);
        chk("midtx_rst_rx_data", 32'(rx_data), 0);

        hold(50);
        chk("events_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
